// File: rtl/simon_pkg.sv
// Shared types and helpers for the digit-serial Simon datapath and its key schedule.
package simon_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StRound, StUnload} state_e;

  localparam int unsigned MaxN = 64;

  function automatic bit legal_n(input int unsigned n);
    return (n == 16) || (n == 24) || (n == 32) || (n == 48) || (n == 64);
  endfunction

  // Rotate left within the low n bits of a MaxN-wide container.
  function automatic logic [MaxN-1:0] rol(input logic [MaxN-1:0] v, input int unsigned n,
                                          input int unsigned amt);
    logic [MaxN-1:0] mask;
    logic [MaxN-1:0] vm;
    mask = (n >= MaxN) ? '1 : ((64'd1 << n) - 64'd1);
    vm   = v & mask;
    return ((vm << amt) | (vm >> (n - amt))) & mask;
  endfunction

  function automatic logic [MaxN-1:0] simon_f(input logic [MaxN-1:0] v, input int unsigned n);
    return (rol(v, n, 1) & rol(v, n, 8)) ^ rol(v, n, 2);
  endfunction

endpackage

// File: rtl/simon_round_f.sv
// Combinational Simon round function f(v) = (rol1 & rol8) ^ rol2 on an N-bit word.
module simon_round_f #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] v,
  output logic [N-1:0] f
);

  logic [N-1:0] rol1, rol2, rol8;

  assign rol1 = {v[N-2:0], v[N-1]};
  assign rol2 = {v[N-3:0], v[N-1:N-2]};
  assign rol8 = {v[N-9:0], v[N-1:N-8]};
  assign f    = (rol1 & rol8) ^ rol2;

endmodule

// File: rtl/simon_datapath_digit.sv
// Digit-serial Simon datapath: loads a block D bits per cycle, runs ROUNDS rounds with one
// key digit per cycle, then streams the result out with a valid/ready handshake.
module simon_datapath_digit
  import simon_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned D      = 4,
  parameter int unsigned ROUNDS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  input  logic         data_valid,
  input  logic [D-1:0] data_in,
  output logic         data_ready,
  input  logic [D-1:0] key_in,
  output logic         key_rdy,
  output logic [D-1:0] cipher_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [6:0]   round_cnt
);

  localparam int unsigned Digits = N / D;
  localparam int unsigned DigW   = $clog2(2 * Digits);
  localparam logic [DigW-1:0] DigitsW     = DigW'(Digits);
  localparam logic [DigW-1:0] LastDig     = DigW'(2 * Digits - 1);
  localparam logic [DigW-1:0] LastWordDig = DigW'(Digits - 1);

  if ((N % D) != 0 || ROUNDS < 1 || ROUNDS > 127 || !legal_n(N)) begin : g_param_check
    $error("simon_datapath_digit: illegal parameters N=%0d D=%0d ROUNDS=%0d", N, D, ROUNDS);
  end

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [N-1:0]    x_q, x_d, y_q, y_d, s_q, s_d;
  logic [DigW-1:0] dig_q, dig_d, word_dig;
  logic [6:0]      rcnt_q, rcnt_d;
  logic [N-1:0]    f_in, f_out, t;

  // Digit position within the current word (dig spans both x and y during LOAD/UNLOAD).
  assign word_dig = (dig_q >= DigitsW) ? dig_q - DigitsW : dig_q;

  // Encrypt mixes into y using f(x); decrypt mixes into x using f(y).
  assign f_in = mode_q ? y_q : x_q;
  assign t    = (mode_q ? x_q : y_q) ^ f_out;

  simon_round_f #(.N(N)) u_round_f (
    .v (f_in),
    .f (f_out)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    s_d     = s_q;
    dig_d   = dig_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          dig_d   = '0;
          rcnt_d  = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (data_valid) begin
          if (dig_q < DigitsW) x_d[word_dig*D +: D] = data_in;
          else                 y_d[word_dig*D +: D] = data_in;
          if (dig_q == LastDig) begin
            dig_d   = '0;
            state_d = StRound;
          end else begin
            dig_d = dig_q + DigW'(1);
          end
        end
      end
      StRound: begin
        s_d[dig_q*D +: D] = t[dig_q*D +: D] ^ key_in;
        if (dig_q == LastWordDig) begin
          // Commit uses s_d so the digit produced this cycle is included.
          dig_d = '0;
          if (mode_q) begin
            x_d = y_q;
            y_d = s_d;
          end else begin
            x_d = s_d;
            y_d = x_q;
          end
          rcnt_d = rcnt_q + 7'd1;
          if (rcnt_d == 7'(ROUNDS)) state_d = StUnload;
        end else begin
          dig_d = dig_q + DigW'(1);
        end
      end
      StUnload: begin
        if (out_ready) begin
          if (dig_q == LastDig) begin
            dig_d   = '0;
            state_d = StIdle;
          end else begin
            dig_d = dig_q + DigW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      dig_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      s_q     <= s_d;
      dig_q   <= dig_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    cipher_out = '0;
    if (state_q == StUnload) begin
      cipher_out = (dig_q < DigitsW) ? x_q[word_dig*D +: D] : y_q[word_dig*D +: D];
    end
  end

  assign busy       = (state_q != StIdle);
  assign data_ready = (state_q == StLoad);
  assign key_rdy    = (state_q == StRound);
  assign out_valid  = (state_q == StUnload);
  assign round_cnt  = rcnt_q;

endmodule

// File: tb/tb_simon_datapath_digit.sv
// Scoreboard bench for simon_datapath_digit: Simon32/64 (with stalls, start pulses and reset)
// and Simon128/128 known-answer vectors.
module tb_simon_datapath_digit;

  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

  localparam logic [15:0] PX = 16'h6565, PY = 16'h6877;
  localparam logic [15:0] CX = 16'hc69b, CY = 16'he9bb;
  localparam logic [63:0] BPX = 64'h6373656420737265, BPY = 64'h6c6c657661727420;
  localparam logic [63:0] BCX = 64'h49681b1e1e54fe3f, BCY = 64'h65aa832af84e0bbc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Simon32/64 instance
  logic       a_reset, a_start, a_mode, a_data_valid, a_out_ready;
  logic [3:0] a_data_in;
  logic [3:0] a_key_in = '0;
  logic       a_data_ready, a_key_rdy, a_out_valid, a_busy;
  logic [3:0] a_cipher_out;
  logic [6:0] a_round_cnt;

  // Simon128/128 instance
  logic       b_reset, b_start, b_mode, b_data_valid, b_out_ready;
  logic [7:0] b_data_in;
  logic [7:0] b_key_in = '0;
  logic       b_data_ready, b_key_rdy, b_out_valid, b_busy;
  logic [7:0] b_cipher_out;
  logic [6:0] b_round_cnt;

  simon_datapath_digit #(.N(16), .D(4), .ROUNDS(32)) u_dut_a (
    .clk        (clk),
    .reset      (a_reset),
    .start      (a_start),
    .mode       (a_mode),
    .data_valid (a_data_valid),
    .data_in    (a_data_in),
    .data_ready (a_data_ready),
    .key_in     (a_key_in),
    .key_rdy    (a_key_rdy),
    .cipher_out (a_cipher_out),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .busy       (a_busy),
    .round_cnt  (a_round_cnt)
  );

  simon_datapath_digit #(.N(64), .D(8), .ROUNDS(68)) u_dut_b (
    .clk        (clk),
    .reset      (b_reset),
    .start      (b_start),
    .mode       (b_mode),
    .data_valid (b_data_valid),
    .data_in    (b_data_in),
    .data_ready (b_data_ready),
    .key_in     (b_key_in),
    .key_rdy    (b_key_rdy),
    .cipher_out (b_cipher_out),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .busy       (b_busy),
    .round_cnt  (b_round_cnt)
  );

  logic [15:0] ka[32];
  logic [15:0] a_keys[32];
  logic [63:0] kb[68];
  logic [3:0]  a_q[$];
  logic [7:0]  b_q[$];
  int          ak = 0;
  int          bk = 0;
  int unsigned a_cyc0 = 0;

  // Key sources: present the next key digit whenever the DUT consumes one.
  always @(negedge clk) begin
    if (a_key_rdy) begin
      a_key_in = a_keys[(ak / 4) % 32][(ak % 4) * 4 +: 4];
      ak++;
    end else begin
      ak = 0;
    end
    if (b_key_rdy) begin
      b_key_in = kb[(bk / 8) % 68][(bk % 8) * 8 +: 8];
      bk++;
    end else begin
      bk = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ror16(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction

  task automatic expand_keys();
    logic [15:0] t16;
    logic [63:0] t64;
    ka[0] = 16'h0100; ka[1] = 16'h0908; ka[2] = 16'h1110; ka[3] = 16'h1918;
    for (int i = 4; i < 32; i++) begin
      t16   = ror16(ka[i-1], 3) ^ ka[i-3];
      t16   = t16 ^ ror16(t16, 1);
      ka[i] = ~ka[i-4] ^ t16 ^ 16'(Z0[61 - ((i - 4) % 62)]) ^ 16'd3;
    end
    kb[0] = 64'h0706050403020100; kb[1] = 64'h0f0e0d0c0b0a0908;
    for (int i = 2; i < 68; i++) begin
      t64   = ror64(kb[i-1], 3);
      t64   = t64 ^ ror64(t64, 1);
      kb[i] = ~kb[i-2] ^ t64 ^ 64'(Z2[61 - ((i - 2) % 62)]) ^ 64'd3;
    end
  endtask

  task automatic a_push(input logic [15:0] x, input logic [15:0] y);
    for (int i = 0; i < 4; i++) a_q.push_back(x[i*4 +: 4]);
    for (int i = 0; i < 4; i++) a_q.push_back(y[i*4 +: 4]);
  endtask

  // Called at #1 after a rising edge; drives start for one cycle.
  task automatic a_begin(input logic m);
    for (int i = 0; i < 32; i++) a_keys[i] = m ? ka[31-i] : ka[i];
    a_mode  = m;
    a_start = 1'b1;
    a_cyc0  = cyc;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("a_data_ready", 64'(a_data_ready), 64'd1);
  endtask

  task automatic a_load(input logic [15:0] x, input logic [15:0] y, input bit stall,
                        input bit pulse, output int stalls);
    logic [31:0] blk;
    blk    = {y, x};
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        a_data_valid = 1'b0;
        stalls++;
        @(posedge clk); #1;
      end
      a_data_valid = 1'b1;
      a_data_in    = blk[i*4 +: 4];
      a_start      = pulse && (i == 3);
      if (a_start) a_mode = ~a_mode;
      @(posedge clk); #1;
    end
    a_data_valid = 1'b0;
    a_start      = 1'b0;
  endtask

  task automatic a_unload(input bit stall, input bit pulse, input int stalls_in);
    int          got    = 0;
    int          guard  = 0;
    int          ostall = 0;
    bit          pulsed = 0;
    int unsigned c_end  = 0;
    while (got < 8 && guard < 2000) begin
      a_start = 1'b0;
      if (a_out_valid) begin
        if (pulse && !pulsed) begin
          a_start = 1'b1;
          a_mode  = ~a_mode;
          pulsed  = 1;
        end
        a_out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (a_out_ready) begin
          check("a_out", 64'(a_cipher_out), 64'(a_q.pop_front()));
          got++;
          c_end = cyc;
        end else begin
          check("a_hold", 64'(a_cipher_out), 64'(a_q[0]));
          ostall++;
        end
      end else begin
        a_out_ready = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    a_start     = 1'b0;
    a_out_ready = 1'b0;
    a_q.delete();
    check("a_done", 64'(got), 64'd8);
    check("a_cycles", 64'(c_end - a_cyc0 + 1), 64'(145 + stalls_in + ostall));
    check("a_busy_idle", 64'(a_busy), 64'd0);
    check("a_round_cnt", 64'(a_round_cnt), 64'd32);
  endtask

  task automatic b_run();
    logic [127:0] blk;
    logic [127:0] exp_blk;
    int           got   = 0;
    int           guard = 0;
    int unsigned  c0;
    int unsigned  c_end = 0;
    blk     = {BPY, BPX};
    exp_blk = {BCY, BCX};
    for (int i = 0; i < 16; i++) b_q.push_back(exp_blk[i*8 +: 8]);
    b_mode  = 1'b0;
    b_start = 1'b1;
    c0      = cyc;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b_data_valid = 1'b1;
      b_data_in    = blk[i*8 +: 8];
      @(posedge clk); #1;
    end
    b_data_valid = 1'b0;
    b_out_ready  = 1'b1;
    while (got < 16 && guard < 2000) begin
      if (b_out_valid) begin
        check("b_out", 64'(b_cipher_out), 64'(b_q.pop_front()));
        got++;
        c_end = cyc;
      end
      @(posedge clk); #1;
      guard++;
    end
    b_out_ready = 1'b0;
    b_q.delete();
    check("b_done", 64'(got), 64'd16);
    check("b_cycles", 64'(c_end - c0 + 1), 64'd577);
    check("b_round_cnt", 64'(b_round_cnt), 64'd68);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int g;
    expand_keys();
    a_reset = 1'b1; a_start = 1'b0; a_mode = 1'b0; a_data_valid = 1'b0;
    a_data_in = '0; a_out_ready = 1'b0;
    b_reset = 1'b1; b_start = 1'b0; b_mode = 1'b0; b_data_valid = 1'b0;
    b_data_in = '0; b_out_ready = 1'b0;
    for (int i = 0; i < 32; i++) a_keys[i] = ka[i];
    repeat (3) @(posedge clk);
    #1;
    a_reset = 1'b0;
    b_reset = 1'b0;
    check("rst_a_busy", 64'(a_busy), 64'd0);
    check("rst_a_outs", 64'({a_data_ready, a_key_rdy, a_out_valid, a_cipher_out, a_round_cnt}),
          64'd0);
    check("rst_b_outs", 64'({b_busy, b_out_valid, b_cipher_out, b_round_cnt}), 64'd0);

    // Encrypt, then decrypt started in the cycle right after the last output transfer.
    a_push(CX, CY); a_begin(1'b0); a_load(PX, PY, 1'b0, 1'b0, s); a_unload(1'b0, 1'b0, s);
    a_push(PX, PY); a_begin(1'b1); a_load(CX, CY, 1'b0, 1'b0, s); a_unload(1'b0, 1'b0, s);

    // Random input and output stalls.
    a_push(CX, CY); a_begin(1'b0); a_load(PX, PY, 1'b1, 1'b0, s); a_unload(1'b1, 1'b0, s);
    a_push(CX, CY); a_begin(1'b0); a_load(PX, PY, 1'b1, 1'b0, s); a_unload(1'b1, 1'b0, s);

    // Stray start/mode pulses in LOAD and UNLOAD.
    a_push(CX, CY); a_begin(1'b0); a_load(PX, PY, 1'b0, 1'b1, s); a_unload(1'b0, 1'b1, s);

    // Reset in the middle of round 10 discards the block.
    a_begin(1'b0); a_load(PX, PY, 1'b0, 1'b0, s);
    g = 0;
    while (a_round_cnt != 7'd10 && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check("a_rcnt10", 64'(a_round_cnt), 64'd10);
    a_reset = 1'b1;
    @(posedge clk); #1;
    a_reset = 1'b0;
    check("a_rst_busy", 64'(a_busy), 64'd0);
    check("a_rst_outs", 64'({a_data_ready, a_key_rdy, a_out_valid, a_cipher_out, a_round_cnt}),
          64'd0);

    a_push(CX, CY); a_begin(1'b0); a_load(PX, PY, 1'b0, 1'b0, s); a_unload(1'b0, 1'b0, s);

    b_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
